mic_frame_packer: RTL



---
 rtl/mic_frame_packer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mic_frame_packer.sv
// Packs one multi-channel sample set per word-select period into a framed byte stream:
// HDR0 HDR1 CNT {ch0 hi, ch0 lo, ... } CSUM, with one pending set buffered behind the active one.
module mic_frame_packer #(
  parameter int         NUM_CH   = 7,
  parameter int         IN_WIDTH = 24,
  parameter logic [7:0] HDR0     = 8'hA5,
  parameter logic [7:0] HDR1     = 8'h5A
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         enable,
  input  logic                         sample_valid,
  input  logic [NUM_CH*IN_WIDTH-1:0]   sample_data,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic [15:0]                  overrun_cnt
);

  localparam int BUF_W = NUM_CH * 16;
  localparam int IDX_W = (2 * NUM_CH > 2) ? $clog2(2 * NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NUM_CH - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR_A = 3'd1;
  localparam logic [2:0] ST_HDR_B = 3'd2;
  localparam logic [2:0] ST_CNT   = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_CSUM  = 3'd5;

  logic [2:0]       r_state;
  logic [BUF_W-1:0] r_pend;
  logic             r_pend_full;
  logic [BUF_W-1:0] r_act;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_cnt;
  logic [7:0]       r_csum;

  logic [BUF_W-1:0] w_trunc;
  logic [2:0]       w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [7:0]       w_byte_nxt;
  logic [7:0]       w_csum_sum;
  logic             w_accept;
  logic             w_take;
  logic             w_done;
  logic             w_write;

  // Keep the top 16 bits of every channel; plain truncation.
  for (genvar gk = 0; gk < NUM_CH; gk++) begin : g_trunc
    assign w_trunc[gk*16 +: 16] = sample_data[gk*IN_WIDTH + IN_WIDTH - 1 -: 16];
  end

  function automatic logic [7:0] data_byte(input logic [BUF_W-1:0] buf_v,
                                           input logic [IDX_W-1:0] idx);
    logic [15:0] word;
    int          ch;
    ch   = int'(idx) / 2;
    word = buf_v[ch*16 +: 16];
    data_byte = idx[0] ? word[7:0] : word[15:8];
  endfunction

  assign w_accept   = tx_valid && tx_ready;
  assign w_csum_sum = r_csum + tx_data;
  assign w_write    = sample_valid && enable && (!r_pend_full || w_take);

  // Next state and the byte presented in that state, so tx_data is registered.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_byte_nxt  = tx_data;
    w_take      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_full) begin
          w_take      = 1'b1;
          w_state_nxt = ST_HDR_A;
          w_byte_nxt  = HDR0;
        end else begin
          w_byte_nxt  = 8'h00;
        end
      end
      ST_HDR_A: begin
        if (w_accept) begin
          w_state_nxt = ST_HDR_B;
          w_byte_nxt  = HDR1;
        end else begin
          w_state_nxt = ST_HDR_A;
        end
      end
      ST_HDR_B: begin
        if (w_accept) begin
          w_state_nxt = ST_CNT;
          w_byte_nxt  = r_cnt;
        end else begin
          w_state_nxt = ST_HDR_B;
        end
      end
      ST_CNT: begin
        if (w_accept) begin
          w_state_nxt = ST_DATA;
          w_idx_nxt   = '0;
          w_byte_nxt  = data_byte(r_act, '0);
        end else begin
          w_state_nxt = ST_CNT;
        end
      end
      ST_DATA: begin
        if (w_accept && (r_idx == LAST_IDX)) begin
          w_state_nxt = ST_CSUM;
          w_byte_nxt  = w_csum_sum;
        end else if (w_accept) begin
          w_idx_nxt   = r_idx + 1'b1;
          w_byte_nxt  = data_byte(r_act, r_idx + 1'b1);
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (w_accept) begin
          w_state_nxt = ST_IDLE;
          w_byte_nxt  = 8'h00;
          w_done      = 1'b1;
        end else begin
          w_state_nxt = ST_CSUM;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_byte_nxt  = 8'h00;
      end
    endcase
  end

  // Frame sequencing, buffers, checksum and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_act       <= '0;
      r_idx       <= '0;
      r_cnt       <= 8'h00;
      r_csum      <= 8'h00;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun_cnt <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      tx_data    <= w_byte_nxt;
      tx_valid   <= (w_state_nxt != ST_IDLE);
      busy       <= (w_state_nxt != ST_IDLE);
      frame_done <= w_done;
      if (w_done) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_take) begin
        r_act  <= r_pend;
        r_csum <= 8'h00;
      end else if (w_accept && ((r_state == ST_CNT) || (r_state == ST_DATA))) begin
        r_csum <= w_csum_sum;
      end
      // A set arriving while IDLE drains pending lands in the freed slot, not an overrun.
      if (w_write) begin
        r_pend      <= w_trunc;
        r_pend_full <= 1'b1;
      end else begin
        if (w_take) begin
          r_pend_full <= 1'b0;
        end
        if (sample_valid && enable && (overrun_cnt != 16'hFFFF)) begin
          overrun_cnt <= overrun_cnt + 16'd1;
        end
      end
    end
  end

endmodule
